// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared FSM state type and default timeout for the unified memory arbiter.
package unified_mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} arb_state_t;
  localparam int ARB_MAX_WAIT = 255;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating wait-cycle counter; hit_o flags the edge on which it reaches MAX_WAIT.
module mem_wait_timer #(
  parameter int MAX_WAIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  localparam int W = $clog2(MAX_WAIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != W'(MAX_WAIT)) ? cnt_q + 1'b1 : cnt_q;
  // Compare the next value so the error register sets on the same edge the count arrives.
  assign hit_o = cnt_d == W'(MAX_WAIT);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: serialises data and fetch accesses onto one memory port, data first,
// stalling the pipeline until every request of the current pipeline cycle has completed.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = ARB_MAX_WAIT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              timeout_err_o
);
  arb_state_t        state_q;
  logic              if_done_q, dm_done_q, mem_req_q, mem_we_q, timeout_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;
  logic              dm_pend, if_pend, busy, at_max;
  assign dm_pend = dm_req_i & ~dm_done_q;
  assign if_pend = if_req_i & ~if_done_q;
  assign busy    = state_q != IDLE;
  assign stall_o       = dm_pend | if_pend;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign if_rdata_o    = if_rdata_q;
  assign dm_rdata_o    = dm_rdata_q;
  assign timeout_err_o = timeout_q;
  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (~busy | mem_ready_i),
    .en_i  (busy & ~mem_ready_i),
    .hit_o (at_max)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q     <= IDLE;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= timeout_q | at_max;
      // Pipeline advances on this edge: start a fresh pipeline cycle.
      if (!stall_o) begin
        if_done_q <= 1'b0;
        dm_done_q <= 1'b0;
      end
      case (state_q)
        IDLE:
          if (dm_pend) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we_i;
            mem_addr_q  <= dm_addr_i;
            mem_wdata_q <= dm_wdata_i;
          end else if (if_pend) begin
            state_q    <= BUSY_I;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr_i;
          end
        BUSY_D:
          if (mem_ready_i) begin
            // A flushed requester still completes, but its result is dropped.
            if (dm_req_i) begin
              dm_done_q <= 1'b1;
              if (!mem_we_q) dm_rdata_q <= mem_rdata_i;
            end
            mem_we_q <= 1'b0;
            if (if_pend) begin
              state_q    <= BUSY_I;
              mem_addr_q <= if_addr_i;
            end else begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end
          end
        BUSY_I:
          if (mem_ready_i) begin
            if (if_req_i) begin
              if_done_q  <= 1'b1;
              if_rdata_q <= mem_rdata_i;
            end
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed tests with a reactive memory model; a monitor checks every
// completed memory transaction against a queue of expected transactions.
module tb_unified_mem_arbiter;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;
  logic        clk, rst_n;
  logic        if_req, dm_req, dm_we, stall, mem_req, mem_we, mem_ready, timeout_err;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [logic [31:0]];
  txn_t        exp_mem[$];
  int          pass_cnt = 0, tot_cnt = 0;
  int          ws = 0, wcnt = 0;
  bit          tie_low = 0, spurious = 0;
  int          n, nreq, nwe;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata), .stall_o(stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready), .timeout_err_o(timeout_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Memory model: answers ws cycles after a request is seen, stores take effect on completion.
  initial begin
    mem_ready = 0;
    mem_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      if (spurious) mem_ready = 1;
      else if (!mem_req || tie_low) begin
        mem_ready = 0;
        wcnt = 0;
      end else if (wcnt == ws) begin
        mem_ready = 1;
        wcnt = 0;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'hBAD0_0000;
      end else begin
        mem_ready = 0;
        wcnt++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && mem_req && mem_ready) begin
      if (exp_mem.size() == 0) chk("mem_unexpected_txn", mem_addr, 32'hFFFF_FFFF);
      else begin
        txn_t e;
        e = exp_mem.pop_front();
        chk("mem_we", mem_we, e.we);
        chk("mem_addr", mem_addr, e.addr);
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
      end
    end
  end

  // One pipeline cycle: call at posedge+1; returns stall cycles, mem_req cycles and mem_we cycles.
  task automatic pipe(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dd,
                      output int ns, output int nr, output int nw);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
    ns = 0; nr = 0; nw = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      nr += int'(mem_req);
      nw += int'(mem_we);
      if (!stall) break;
      ns++;
    end
    @(posedge clk);
    #1;
    if_req = 0; dm_req = 0; dm_we = 0;
  endtask

  initial begin
    rst_n = 0; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    mem[32'h40] = 32'h2008_0005;
    mem[32'h44] = 32'h8C41_0004;
    mem[32'h100] = 32'hDEAD_BEEF;
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_timeout", timeout_err, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    // Fetch only, zero-wait
    ws = 0;
    exp_mem.push_back('{1'b0, 32'h40, 32'h0});
    pipe(1, 32'h40, 0, 0, 0, 0, n, nreq, nwe);
    chk("t1_stall_cycles", n, 2);
    chk("t1_req_cycles", nreq, 1);
    chk("t1_if_rdata", if_rdata, 32'h2008_0005);
    // Load + fetch: load address must go out first
    exp_mem.push_back('{1'b0, 32'h100, 32'h0});
    exp_mem.push_back('{1'b0, 32'h44, 32'h0});
    pipe(1, 32'h44, 1, 0, 32'h100, 0, n, nreq, nwe);
    chk("t2_stall_cycles", n, 3);
    chk("t2_req_cycles", nreq, 2);
    chk("t2_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("t2_if_rdata", if_rdata, 32'h8C41_0004);
    // Store + fetch of the same address, two wait states each
    ws = 2;
    exp_mem.push_back('{1'b1, 32'h80, 32'h1234});
    exp_mem.push_back('{1'b0, 32'h80, 32'h0});
    pipe(1, 32'h80, 1, 1, 32'h80, 32'h1234, n, nreq, nwe);
    chk("t3_stall_cycles", n, 7);
    chk("t3_req_cycles", nreq, 6);
    chk("t3_we_cycles", nwe, 3);
    chk("t3_if_rdata_store_first", if_rdata, 32'h1234);
    chk("t3_dm_rdata_kept", dm_rdata, 32'hDEAD_BEEF);
    // mem_ready while idle is ignored
    spurious = 1;
    repeat (3) @(negedge clk);
    chk("idle_rdy_mem_req", mem_req, 0);
    chk("idle_rdy_stall", stall, 0);
    chk("idle_rdy_if_rdata", if_rdata, 32'h1234);
    spurious = 0;
    @(posedge clk);
    #1;
    // Fetch flushed mid-BUSY_I: completes, result discarded
    exp_mem.push_back('{1'b0, 32'h44, 32'h0});
    if_req = 1; if_addr = 32'h44;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    if_req = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!mem_req) break;
    end
    chk("t6_idle", mem_req, 0);
    chk("t6_stall", stall, 0);
    chk("t6_if_rdata_kept", if_rdata, 32'h1234);
    chk("t6_txn_done", exp_mem.size(), 0);
    @(posedge clk);
    #1;
    ws = 0;
    exp_mem.push_back('{1'b0, 32'h40, 32'h0});
    pipe(1, 32'h40, 0, 0, 0, 0, n, nreq, nwe);
    chk("t6_refetch_stall", n, 2);
    chk("t6_refetch_rdata", if_rdata, 32'h2008_0005);
    // Timeout with mem_ready stuck low
    tie_low = 1;
    dm_req = 1; dm_addr = 32'h200;
    repeat (5) @(negedge clk);
    chk("t4_no_err_yet", timeout_err, 0);
    @(negedge clk);
    chk("t4_err_set", timeout_err, 1);
    repeat (5) @(negedge clk);
    chk("t4_err_sticky", timeout_err, 1);
    chk("t4_req_held", mem_req, 1);
    chk("t4_stall_held", stall, 1);
    @(posedge clk);
    #1;
    dm_req = 0;
    #2 rst_n = 0;
    #1;
    chk("t4_rst_err", timeout_err, 0);
    chk("t4_rst_req", mem_req, 0);
    @(negedge clk) rst_n = 1;
    tie_low = 0;
    @(posedge clk);
    #1;
    // Reset in the second cycle of a BUSY_D wait
    ws = 5;
    dm_req = 1; dm_addr = 32'h100; if_req = 1; if_addr = 32'h48;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t5_req_async", mem_req, 0);
    chk("t5_addr_cleared", mem_addr, 0);
    chk("t5_dm_rdata_cleared", dm_rdata, 0);
    chk("t5_if_rdata_cleared", if_rdata, 0);
    dm_req = 0; if_req = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    ws = 0;
    exp_mem.push_back('{1'b0, 32'h40, 32'h0});
    pipe(1, 32'h40, 0, 0, 0, 0, n, nreq, nwe);
    chk("t5_restart_stall", n, 2);
    chk("t5_restart_rdata", if_rdata, 32'h2008_0005);
    chk("all_txns_seen", exp_mem.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
